// File: rtl/wf_instr_queue_pkg.sv
// wf_instr_queue shared types and sizing.
// Geometry defaults and flush priority for the per-wavefront queue.
package wf_instr_queue_pkg;

  localparam int NUM_WF  = 40;
  localparam int WFID_W  = 6;
  localparam int DEPTH   = 4;
  localparam int INSTR_W = 64;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // A flush discards a same-cycle write/pop to the same wavefront.
  localparam bit FLUSH_BEATS_WR = 1'b1;
  localparam bit FLUSH_BEATS_RD = 1'b1;

endpackage

// File: rtl/wf_instr_queue_if.sv
// wf_instr_queue decode/feeder/flush bundle.
// master drives requests, slave is the queue.
interface wf_instr_queue_if;
  import wf_instr_queue_pkg::*;

  logic               wr_valid;
  logic [WFID_W-1:0]  wr_wfid;
  logic [INSTR_W-1:0] wr_data;
  logic               rd_valid;
  logic [WFID_W-1:0]  rd_wfid;
  logic               flush_valid;
  logic [WFID_W-1:0]  flush_wfid;
  logic               out_valid;
  logic [WFID_W-1:0]  out_wfid;
  logic [INSTR_W-1:0] out_data;
  logic [NUM_WF-1:0]  q_empty;
  logic [NUM_WF-1:0]  q_full;
  logic [NUM_WF-1:0]  q_reset;
  logic               err_overflow;
  logic               err_underflow;

  modport master (
    output wr_valid, wr_wfid, wr_data,
    output rd_valid, rd_wfid,
    output flush_valid, flush_wfid,
    input  out_valid, out_wfid, out_data,
    input  q_empty, q_full, q_reset,
    input  err_overflow, err_underflow
  );

  modport slave (
    input  wr_valid, wr_wfid, wr_data,
    input  rd_valid, rd_wfid,
    input  flush_valid, flush_wfid,
    output out_valid, out_wfid, out_data,
    output q_empty, q_full, q_reset,
    output err_overflow, err_underflow
  );

endinterface

// File: rtl/wfq_slot_fifo.sv
// One wavefront's instruction FIFO.
// Push/pop are self-gated on full/empty; clear wins over both.
module wfq_slot_fifo
  import wf_instr_queue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [INSTR_W-1:0] push_data,
  output logic               empty,
  output logic               full,
  output logic [INSTR_W-1:0] head
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rptr;
  logic [PTR_W-1:0]   wptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

  // Payload storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/wf_instr_queue.sv
// Per-wavefront instruction queue between decode and feeder.
// Macro WFQ_ERR_CHECK_EN enables sticky overflow/underflow flags.
module wf_instr_queue
  import wf_instr_queue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  wf_instr_queue_if.slave  bus
);

  logic [NUM_WF-1:0]  wr_hit, rd_hit, fl_hit;
  logic [NUM_WF-1:0]  push, pop, empty, full;
  logic [INSTR_W-1:0] head [NUM_WF];
  logic [INSTR_W-1:0] head_sel;
  logic               pop_ok;

  logic               out_valid_q;
  logic [WFID_W-1:0]  out_wfid_q;
  logic [INSTR_W-1:0] out_data_q;
  logic [NUM_WF-1:0]  q_reset_q;

  genvar i;
  generate
    for (i = 0; i < NUM_WF; i++) begin : g_slot
      assign wr_hit[i] = bus.wr_valid &&
                         (bus.wr_wfid == WFID_W'(i));
      assign rd_hit[i] = bus.rd_valid &&
                         (bus.rd_wfid == WFID_W'(i));
      assign fl_hit[i] = bus.flush_valid &&
                         (bus.flush_wfid == WFID_W'(i));
      assign push[i] = wr_hit[i] &&
                       !(fl_hit[i] && FLUSH_BEATS_WR);
      assign pop[i]  = rd_hit[i] &&
                       !(fl_hit[i] && FLUSH_BEATS_RD);

      wfq_slot_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push[i]),
        .pop       (pop[i]),
        .clear     (fl_hit[i]),
        .push_data (bus.wr_data),
        .empty     (empty[i]),
        .full      (full[i]),
        .head      (head[i])
      );
    end
  endgenerate

  assign pop_ok = |(pop & ~empty);

  // Head mux for the granted wavefront.
  always_comb begin
    head_sel = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      if (rd_hit[k]) head_sel = head[k];
    end
  end

  // Pop output register and flush pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_wfid_q  <= '0;
      out_data_q  <= '0;
      q_reset_q   <= '0;
    end else begin
      out_valid_q <= pop_ok;
      q_reset_q   <= fl_hit;
      if (pop_ok) begin
        out_wfid_q <= bus.rd_wfid;
        out_data_q <= head_sel;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_wfid  = out_wfid_q;
  assign bus.out_data  = out_data_q;
  assign bus.q_empty   = empty;
  assign bus.q_full    = full;
  assign bus.q_reset   = q_reset_q;

`ifdef WFQ_ERR_CHECK_EN
  logic ovf_ev, unf_ev;
  logic ovf_q, unf_q;

  assign ovf_ev = |(push & full);
  assign unf_ev = |(pop & empty);

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_ev) ovf_q <= 1'b1;
      if (unf_ev) unf_q <= 1'b1;
    end
  end

  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;
`else
  assign bus.err_overflow  = 1'b0;
  assign bus.err_underflow = 1'b0;
`endif

endmodule
